// File: rtl/cascade_sequencer_if.sv
// Handshake bundle around the cascade sequencer: window in,
// weak-count ROM, feature issue, stage decision and detection out.
interface cascade_sequencer_if #(
    parameter int STAGE_NUM     = 25,
    parameter int MAX_WEAKCOUNT = 211,
    parameter int FEATURE_NUM   = 2913,
    parameter int W_WIN         = 16
);
    localparam int W_ADDR_STAGE = $clog2(STAGE_NUM);
    localparam int W_ADDR_FEAT  = $clog2(FEATURE_NUM);
    localparam int W_WCNT       = $clog2(MAX_WEAKCOUNT + 1);

    logic                    win_valid;
    logic                    win_ready;
    logic [W_WIN-1:0]        win_id;
    logic [W_ADDR_STAGE-1:0] wcnt_addr;
    logic [W_WCNT-1:0]       wcnt_data;
    logic                    feat_valid;
    logic                    feat_ready;
    logic [W_ADDR_FEAT-1:0]  feat_addr;
    logic                    feat_eot;
    logic                    stage_clear;
    logic                    res_valid;
    logic                    res_ready;
    logic                    res_pass;
    logic                    det_valid;
    logic                    det_ready;
    logic                    det;
    logic [W_WIN-1:0]        det_id;

    modport master (
        input  win_valid, win_id, wcnt_data, feat_ready,
        input  res_valid, res_pass, det_ready,
        output win_ready, wcnt_addr, feat_valid, feat_addr,
        output feat_eot, stage_clear, res_ready,
        output det_valid, det, det_id
    );

    modport slave (
        output win_valid, win_id, wcnt_data, feat_ready,
        output res_valid, res_pass, det_ready,
        input  win_ready, wcnt_addr, feat_valid, feat_addr,
        input  feat_eot, stage_clear, res_ready,
        input  det_valid, det, det_id
    );
endinterface

// File: rtl/cascade_sequencer.sv
// Per-window Haar cascade stage scheduler with early reject exit.
// Define CASCADE_STATS_EN to add saturating window/face/feature counters.
module cascade_sequencer #(
    parameter int STAGE_NUM     = 25,
    parameter int MAX_WEAKCOUNT = 211,
    parameter int FEATURE_NUM   = 2913,
    parameter int W_WIN         = 16
) (
    input  logic                clk,
    input  logic                rst,
    cascade_sequencer_if.master bus
`ifdef CASCADE_STATS_EN
    ,
    output logic [31:0]         stat_win,
    output logic [31:0]         stat_face,
    output logic [31:0]         stat_feat
`endif
);
    localparam int W_ADDR_STAGE = $clog2(STAGE_NUM);
    localparam int W_ADDR_FEAT  = $clog2(FEATURE_NUM);
    localparam int W_WCNT       = $clog2(MAX_WEAKCOUNT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        ISSUE,
        WAIT_RES,
        REPORT
    } state_t;

    state_t                  state_q, state_d;
    logic [W_ADDR_STAGE-1:0] stage_q, stage_d;
    logic [W_ADDR_FEAT-1:0]  base_q, base_d;
    logic [W_WCNT-1:0]       idx_q, idx_d;
    logic [W_WCNT-1:0]       cnt_q, cnt_d;
    logic [W_WIN-1:0]        id_q, id_d;
    logic                    det_q, det_d;
    logic                    clr_q, clr_d;
    logic                    last_stage;
    logic                    last_feat;

    assign last_stage = (stage_q == W_ADDR_STAGE'(STAGE_NUM - 1));
    assign last_feat  = (idx_q == cnt_q - W_WCNT'(1));

    assign bus.win_ready   = (state_q == IDLE);
    assign bus.wcnt_addr   = stage_q;
    assign bus.feat_valid  = (state_q == ISSUE);
    assign bus.feat_addr   = base_q + W_ADDR_FEAT'(idx_q);
    assign bus.feat_eot    = (state_q == ISSUE) && last_feat;
    assign bus.stage_clear = clr_q;
    assign bus.res_ready   = (state_q == WAIT_RES);
    assign bus.det_valid   = (state_q == REPORT);
    assign bus.det         = det_q;
    assign bus.det_id      = id_q;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        base_d  = base_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        det_d   = det_q;
        clr_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.win_valid) begin
                    id_d    = bus.win_id;
                    stage_d = '0;
                    base_d  = '0;
                    clr_d   = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: state_d = FETCH;
            // ROM data for stage_q is valid here; empty stages pass
            FETCH: begin
                cnt_d = bus.wcnt_data;
                idx_d = '0;
                if (bus.wcnt_data == '0) begin
                    if (last_stage) begin
                        det_d   = 1'b1;
                        state_d = REPORT;
                    end else begin
                        stage_d = stage_q + W_ADDR_STAGE'(1);
                        state_d = LOAD;
                    end
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.feat_ready) begin
                    idx_d = idx_q + W_WCNT'(1);
                    if (last_feat) begin
                        base_d  = base_q + W_ADDR_FEAT'(cnt_q);
                        state_d = WAIT_RES;
                    end
                end
            end
            WAIT_RES: begin
                if (bus.res_valid) begin
                    if (!bus.res_pass) begin
                        det_d   = 1'b0;
                        state_d = REPORT;
                    end else if (last_stage) begin
                        det_d   = 1'b1;
                        state_d = REPORT;
                    end else begin
                        stage_d = stage_q + W_ADDR_STAGE'(1);
                        state_d = LOAD;
                    end
                end
            end
            REPORT: begin
                if (bus.det_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            stage_q <= '0;
            base_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
            det_q   <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            det_q   <= det_d;
            clr_q   <= clr_d;
        end
    end

`ifdef CASCADE_STATS_EN
    logic det_hs;
    logic feat_hs;

    assign det_hs  = (state_q == REPORT) && bus.det_ready;
    assign feat_hs = (state_q == ISSUE) && bus.feat_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_win  <= '0;
            stat_face <= '0;
            stat_feat <= '0;
        end else begin
            if (det_hs && stat_win != '1)
                stat_win <= stat_win + 32'd1;
            if (det_hs && det_q && stat_face != '1)
                stat_face <= stat_face + 32'd1;
            if (feat_hs && stat_feat != '1)
                stat_feat <= stat_feat + 32'd1;
        end
    end
`endif
endmodule
